// File: rtl/datamover_job_launcher.sv
// Periph-bus initiator that acquires a datamover HWPE context, programs the job
// registers from a latched descriptor, triggers the job and reports completion.
module datamover_job_launcher #(
  parameter logic [31:0] HWPE_BASE  = 32'h0000_0000,
  parameter logic [31:0] PARAM_OFS  = 32'h0000_0040,
  parameter int unsigned N_PARAMS   = 13,
  parameter int unsigned ID_WIDTH   = 10,
  parameter int unsigned RETRY_WAIT = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    job_valid_i,
  output logic                    job_ready_o,
  input  logic [N_PARAMS*32-1:0]  job_params_i,
  output logic                    job_done_o,
  output logic [7:0]              job_id_o,
  output logic                    busy_o,
  output logic                    periph_req_o,
  input  logic                    periph_gnt_i,
  output logic [31:0]             periph_add_o,
  output logic                    periph_wen_o,
  output logic [3:0]              periph_be_o,
  output logic [31:0]             periph_data_o,
  output logic [ID_WIDTH-1:0]     periph_id_o,
  input  logic                    periph_rvalid_i,
  input  logic [31:0]             periph_rdata_i,
  input  logic                    evt_i
);

  localparam int unsigned K_W  = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1;
  localparam int unsigned BO_W = $clog2(RETRY_WAIT + 1);

  localparam logic [K_W-1:0]  K_LAST     = K_W'(N_PARAMS - 1);
  localparam logic [BO_W-1:0] BO_LAST    = BO_W'(RETRY_WAIT - 1);
  localparam logic [31:0]     TRIG_ADDR  = HWPE_BASE;
  localparam logic [31:0]     ACQ_ADDR   = HWPE_BASE + 32'h0000_0004;
  localparam logic [31:0]     PARAM_BASE = HWPE_BASE + PARAM_OFS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ_REQ,
    S_ACQ_RSP,
    S_BACKOFF,
    S_PROG,
    S_TRIG,
    S_WAIT_EVT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [K_W-1:0]  k_q, k_d;
  logic [BO_W-1:0] bo_q, bo_d;
  logic [7:0]      id_q, id_d;
  logic [31:0]     params_q [N_PARAMS];
  logic            accept;

  // Only the context ID and the "no free context" flag of the acquire word matter.
  logic unused_rdata;
  assign unused_rdata = ^periph_rdata_i[30:8];

  assign accept = job_valid_i && (state_q == S_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      bo_q    <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bo_q    <= bo_d;
      id_q    <= id_d;
    end
  end

  // NOTE: the descriptor store is a small register array, so it is cleared on
  // reset like any other state; a RAM macro would not be reset this way.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(N_PARAMS); i++) params_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < int'(N_PARAMS); i++) params_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < int'(N_PARAMS); i++) params_q[i] <= job_params_i[32*i +: 32];
    end
  end

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    bo_d    = bo_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE:     if (job_valid_i) state_d = S_ACQ_REQ;
      S_ACQ_REQ:  if (periph_gnt_i) state_d = S_ACQ_RSP;
      S_ACQ_RSP: begin
        if (periph_rvalid_i) begin
          if (periph_rdata_i[31]) begin
            state_d = S_BACKOFF;
            bo_d    = '0;
          end else begin
            state_d = S_PROG;
            id_d    = periph_rdata_i[7:0];
            k_d     = '0;
          end
        end
      end
      S_BACKOFF: begin
        if (bo_q == BO_LAST) state_d = S_ACQ_REQ;
        else                 bo_d    = bo_q + 1'b1;
      end
      S_PROG: begin
        if (periph_gnt_i) begin
          if (k_q == K_LAST) state_d = S_TRIG;
          else               k_d     = k_q + 1'b1;
        end
      end
      S_TRIG:     if (periph_gnt_i) state_d = S_WAIT_EVT;
      S_WAIT_EVT: if (evt_i) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    // Soft clear abandons any transaction in flight, even one not yet granted.
    if (clear_i) begin
      state_d = S_IDLE;
      k_d     = '0;
      bo_d    = '0;
      id_d    = '0;
    end
  end

  // Request fields derive only from registered state, so they hold until gnt.
  always_comb begin
    periph_req_o  = 1'b0;
    periph_add_o  = '0;
    periph_wen_o  = 1'b0;
    periph_data_o = '0;
    case (state_q)
      S_ACQ_REQ: begin
        periph_req_o = 1'b1;
        periph_add_o = ACQ_ADDR;
        periph_wen_o = 1'b1;
      end
      S_PROG: begin
        periph_req_o  = 1'b1;
        periph_add_o  = PARAM_BASE + 32'({k_q, 2'b00});
        periph_data_o = params_q[k_q];
      end
      S_TRIG: begin
        periph_req_o = 1'b1;
        periph_add_o = TRIG_ADDR;
      end
      default: ;
    endcase
  end

  assign periph_be_o = {4{periph_req_o}};
  assign periph_id_o = '0;
  assign job_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign job_done_o  = (state_q == S_DONE);
  assign job_id_o    = id_q;

endmodule

// File: tb/tb_datamover_job_launcher.sv
// Bench for datamover_job_launcher: a periph slave plus a transaction-level model
// of the expected bus traffic, job IDs and completion pulses.
module tb_datamover_job_launcher;

  localparam int          N    = 13;
  localparam int          RW   = 8;
  localparam int          ID_W = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] OFS  = 32'h0000_0040;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              clear_i = 1'b0;
  logic              job_valid_i = 1'b0;
  logic              job_ready_o;
  logic [N*32-1:0]   job_params_i = '0;
  logic              job_done_o;
  logic [7:0]        job_id_o;
  logic              busy_o;
  logic              periph_req_o;
  logic              periph_gnt_i = 1'b0;
  logic [31:0]       periph_add_o;
  logic              periph_wen_o;
  logic [3:0]        periph_be_o;
  logic [31:0]       periph_data_o;
  logic [ID_W-1:0]   periph_id_o;
  logic              periph_rvalid_i = 1'b0;
  logic [31:0]       periph_rdata_i = '0;
  logic              evt_i;
  logic              evt_man = 1'b0;
  logic              evt_auto = 1'b0;

  assign evt_i = evt_man | evt_auto;

  always #5 clk_i = ~clk_i;

  datamover_job_launcher #(
    .HWPE_BASE (BASE),
    .PARAM_OFS (OFS),
    .N_PARAMS  (N),
    .ID_WIDTH  (ID_W),
    .RETRY_WAIT(RW)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .job_valid_i    (job_valid_i),
    .job_ready_o    (job_ready_o),
    .job_params_i   (job_params_i),
    .job_done_o     (job_done_o),
    .job_id_o       (job_id_o),
    .busy_o         (busy_o),
    .periph_req_o   (periph_req_o),
    .periph_gnt_i   (periph_gnt_i),
    .periph_add_o   (periph_add_o),
    .periph_wen_o   (periph_wen_o),
    .periph_be_o    (periph_be_o),
    .periph_data_o  (periph_data_o),
    .periph_id_o    (periph_id_o),
    .periph_rvalid_i(periph_rvalid_i),
    .periph_rdata_i (periph_rdata_i),
    .evt_i          (evt_i)
  );

  typedef struct packed {
    logic        wen;
    logic [31:0] add;
    logic [31:0] data;
  } txn_t;

  // Model: expected bus transactions, acquire answers, and job IDs, in order.
  txn_t        exp_q [$];
  logic [31:0] acq_q [$];
  logic [7:0]  id_q  [$];
  int          rd_cyc [$];
  int          rd_idx = 0, acq_idx = 0, id_idx = 0;
  int          total = 0, bad = 0, cyc = 0, dones = 0;
  logic [31:0] cur_p [N];

  // Slave / event-responder state.
  logic        armed = 1'b0, done_due = 1'b0, in_txn = 1'b0, rsp_pend = 1'b0, cd_on = 1'b0;
  logic [31:0] rsp_data = '0;
  int          stall_left = 0, cd = 0;
  txn_t        held;
  int          stall_max = 0;
  int          auto_dly = 2;
  logic [31:0] stall_at = 32'hFFFF_FFFF;
  int          flush_tgl = 0, flush_seen = 0, flush_exp = 0, flush_id = 0, flush_acq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string what);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", what, cyc);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_params(input logic [31:0] seed);
    for (int k = 0; k < N; k++) cur_p[k] = seed + 32'h0102_0304 * 32'(k + 1);
  endtask

  function automatic logic [N*32-1:0] pack_params();
    logic [N*32-1:0] r;
    for (int k = 0; k < N; k++) r[32*k +: 32] = cur_p[k];
    return r;
  endfunction

  // One acquire attempt; a successful one is followed by N parameter writes and the trigger.
  task automatic add_acq(input logic [31:0] r);
    txn_t t;
    t = '{wen: 1'b1, add: BASE + 32'h4, data: 32'h0};
    exp_q.push_back(t);
    acq_q.push_back(r);
    if (!r[31]) begin
      id_q.push_back(r[7:0]);
      for (int k = 0; k < N; k++) begin
        t = '{wen: 1'b0, add: BASE + OFS + 32'(4 * k), data: cur_p[k]};
        exp_q.push_back(t);
      end
      t = '{wen: 1'b0, add: BASE, data: 32'h0};
      exp_q.push_back(t);
    end
  endtask

  task automatic send_job(input logic [N*32-1:0] p);
    int n;
    n = 0;
    job_params_i = p;
    job_valid_i  = 1'b1;
    while (!job_ready_o && n < 400) begin
      tick();
      n++;
    end
    if (!job_ready_o) fail("job not accepted");
    tick();
    job_valid_i = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int c;
    c = 0;
    while (dones < n && c < budget) begin
      tick();
      c++;
    end
    if (dones < n) fail("timeout waiting for job_done_o");
  endtask

  task automatic wait_req_at(input logic [31:0] addr, input int budget);
    int c;
    c = 0;
    while (!(periph_req_o && periph_add_o == addr) && c < budget) begin
      tick();
      c++;
    end
    if (!(periph_req_o && periph_add_o == addr)) fail("timeout waiting for request");
  endtask

  // Per-cycle slave and compare step, run at every falling edge.
  task automatic mon_step();
    txn_t e;
    logic evt_now;
    cyc++;
    if (flush_tgl != flush_seen) begin
      flush_seen = flush_tgl;
      rd_idx     = flush_exp;
      id_idx     = flush_id;
      acq_idx    = flush_acq;
      in_txn     = 1'b0;
      armed      = 1'b0;
      cd_on      = 1'b0;
      rsp_pend   = 1'b0;
    end
    check("job_done_o", 32'(job_done_o), 32'(done_due));
    if (done_due) begin
      if (id_idx < id_q.size()) begin
        check("job_id_o at done", 32'(job_id_o), 32'(id_q[id_idx]));
        id_idx++;
      end else fail("done without an outstanding job");
      dones++;
    end
    periph_rvalid_i = rsp_pend;
    periph_rdata_i  = rsp_pend ? rsp_data : 32'h0;
    rsp_pend        = 1'b0;
    evt_auto = 1'b0;
    if (armed && cd_on) begin
      if (cd == 0) begin
        evt_auto = 1'b1;
        cd_on    = 1'b0;
      end else cd--;
    end
    evt_now  = evt_auto | evt_man;
    done_due = armed && evt_now;
    if (done_due) armed = 1'b0;
    periph_gnt_i = 1'b0;
    if (periph_req_o) begin
      if (!in_txn) begin
        in_txn     = 1'b1;
        held       = '{wen: periph_wen_o, add: periph_add_o, data: periph_data_o};
        stall_left = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
      end else begin
        check("held add", periph_add_o, held.add);
        check("held data", periph_data_o, held.data);
        check("held wen", 32'(periph_wen_o), 32'(held.wen));
      end
      if (stall_left == 0 && periph_add_o != stall_at) begin
        periph_gnt_i = 1'b1;
        in_txn       = 1'b0;
        check("periph_be_o", 32'(periph_be_o), 32'hF);
        check("periph_id_o", 32'(periph_id_o), 32'h0);
        if (rd_idx < exp_q.size()) begin
          e = exp_q[rd_idx];
          rd_idx++;
          check("bus wen", 32'(periph_wen_o), 32'(e.wen));
          check("bus add", periph_add_o, e.add);
          if (!e.wen) check("bus data", periph_data_o, e.data);
        end else fail("unexpected request");
        rsp_pend = 1'b1;
        if (periph_wen_o) begin
          rd_cyc.push_back(cyc);
          if (acq_idx < acq_q.size()) begin
            rsp_data = acq_q[acq_idx];
            acq_idx++;
          end else begin
            fail("read with no acquire answer queued");
            rsp_data = 32'h8000_0000;
          end
        end else begin
          rsp_data = 32'hDEAD_BEEF;
          if (periph_add_o == BASE) begin
            armed = 1'b1;
            cd_on = (auto_dly >= 0);
            cd    = auto_dly;
          end
        end
      end else if (stall_left > 0) stall_left--;
    end else if (in_txn) begin
      fail("req dropped before gnt");
      in_txn = 1'b0;
    end
  endtask

  initial begin
    logic [N*32-1:0] pa, pb;
    int s, r0, c;
    fork
      forever begin
        @(negedge clk_i);
        mon_step();
      end
      begin
        #400000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
      end
    join_none

    // Reset values.
    repeat (3) tick();
    check("reset job_ready_o", 32'(job_ready_o), 32'h1);
    check("reset busy_o", 32'(busy_o), 32'h0);
    check("reset periph_req_o", 32'(periph_req_o), 32'h0);
    check("reset job_done_o", 32'(job_done_o), 32'h0);
    check("reset job_id_o", 32'(job_id_o), 32'h0);
    check("reset periph_add_o", periph_add_o, 32'h0);
    check("reset periph_data_o", periph_data_o, 32'h0);
    check("reset periph_wen_o", 32'(periph_wen_o), 32'h0);
    rst_i = 1'b0;
    tick();

    // Event while idle is ignored.
    evt_man = 1'b1;
    tick();
    evt_man = 1'b0;
    tick();
    check("idle evt busy_o", 32'(busy_o), 32'h0);

    // Job 1: immediate acquire of context 0.
    set_params(32'hA000_0000);
    s = exp_q.size();
    add_acq(32'h0000_0000);
    check("model job1 length", 32'(exp_q.size() - s), 32'd15);
    check("model first param add", exp_q[s+1].add, 32'h0000_0040);
    check("model first param data", exp_q[s+1].data, cur_p[0]);
    check("model last param add", exp_q[s+13].add, 32'h0000_0070);
    check("model trigger add", exp_q[s+14].add, 32'h0000_0000);
    check("model trigger data", exp_q[s+14].data, 32'h0000_0000);
    send_job(pack_params());
    wait_dones(1, 200);
    check("job1 job_id_o", 32'(job_id_o), 32'h00);
    check("job1 ready after done", 32'(job_ready_o), 32'h1);
    check("job1 all txns", 32'(rd_idx), 32'(exp_q.size()));

    // Job 2: two refusals, then context 1.
    set_params(32'hB000_0000);
    add_acq(32'hFFFF_FFFF);
    add_acq(32'hFFFF_FFFF);
    add_acq(32'h0000_0001);
    r0 = rd_cyc.size();
    send_job(pack_params());
    wait_dones(2, 300);
    check("job2 job_id_o", 32'(job_id_o), 32'h01);
    check("job2 acquire reads", 32'(rd_cyc.size() - r0), 32'd3);
    if (rd_cyc.size() - r0 >= 3) begin
      // grant cycle, response cycle, then RETRY_WAIT idle cycles
      check("retry spacing 1", 32'(rd_cyc[r0+1] - rd_cyc[r0] - 2), 32'(RW));
      check("retry spacing 2", 32'(rd_cyc[r0+2] - rd_cyc[r0+1] - 2), 32'(RW));
    end
    check("job2 all txns", 32'(rd_idx), 32'(exp_q.size()));

    // Job 3: random grant stalls.
    stall_max = 5;
    set_params(32'hC000_0000);
    add_acq(32'h0000_0007);
    send_job(pack_params());
    wait_dones(3, 1500);
    stall_max = 0;
    check("job3 job_id_o", 32'(job_id_o), 32'h07);
    check("job3 all txns", 32'(rd_idx), 32'(exp_q.size()));

    // Job 4: soft clear while the k=6 write is pending.
    set_params(32'hD000_0000);
    add_acq(32'h0000_0002);
    stall_at = 32'h0000_0058;
    send_job(pack_params());
    wait_req_at(32'h0000_0058, 100);
    check("k6 data", periph_data_o, cur_p[6]);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear periph_req_o", 32'(periph_req_o), 32'h0);
    check("clear job_ready_o", 32'(job_ready_o), 32'h1);
    check("clear busy_o", 32'(busy_o), 32'h0);
    check("clear job_id_o", 32'(job_id_o), 32'h0);
    flush_exp = exp_q.size();
    flush_id  = id_q.size();
    flush_acq = acq_q.size();
    flush_tgl++;
    stall_at  = 32'hFFFF_FFFF;
    tick();

    // Job 5: fresh job; event during PROG ignored, event in WAIT_EVT completes it.
    auto_dly = -1;
    set_params(32'hE000_0000);
    add_acq(32'h0000_0003);
    send_job(pack_params());
    wait_req_at(32'h0000_0050, 100);
    evt_man = 1'b1;
    tick();
    evt_man = 1'b0;
    c = 0;
    while (rd_idx < exp_q.size() && c < 100) begin
      tick();
      c++;
    end
    repeat (5) tick();
    check("wait_evt busy_o", 32'(busy_o), 32'h1);
    check("no done before evt", 32'(dones), 32'd3);
    evt_man = 1'b1;
    tick();
    evt_man = 1'b0;
    wait_dones(4, 20);
    check("job5 job_id_o", 32'(job_id_o), 32'h03);
    check("job5 all txns", 32'(rd_idx), 32'(exp_q.size()));

    // Jobs 6/7: back to back, second descriptor presented while busy.
    auto_dly = 1;
    set_params(32'h1234_0000);
    add_acq(32'h0000_0205);
    pa = pack_params();
    set_params(32'h5678_0000);
    add_acq(32'h7FFF_FF0A);
    pb = pack_params();
    send_job(pa);
    job_params_i = pb;
    job_valid_i  = 1'b1;
    c = 0;
    while (!job_done_o && c < 200) begin
      tick();
      c++;
    end
    if (!job_done_o) fail("timeout waiting for first back-to-back done");
    check("b2b ready during done", 32'(job_ready_o), 32'h0);
    check("b2b first id", 32'(job_id_o), 32'h05);
    tick();
    check("b2b ready after done", 32'(job_ready_o), 32'h1);
    tick();
    check("b2b second accepted", 32'(busy_o), 32'h1);
    job_valid_i = 1'b0;
    wait_dones(6, 300);
    check("b2b second id", 32'(job_id_o), 32'h0A);
    check("b2b all txns", 32'(rd_idx), 32'(exp_q.size()));
    check("total dones", 32'(dones), 32'd6);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
